// File: rtl/instr_fetch_ctrl_pkg.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_ctrl_pkg
// Purpose  : Fetch address window, reset PC, NOP word and fetch FSM encodings.
// Revision : 1.0 - initial release
// ============================================================================
package instr_fetch_ctrl_pkg;

   localparam logic [31:0] c_reset_pc   = 32'h0040_0000;
   localparam logic [31:0] c_text_base  = 32'h0040_0000;
   localparam logic [31:0] c_text_limit = 32'h0040_0400;
   localparam logic [31:0] c_nop        = 32'h0000_0000;
   localparam int          c_depth      = 4;

   localparam logic [0:0]  c_st_run     = 1'b0;
   localparam logic [0:0]  c_st_fault   = 1'b1;

   // A fetch address is legal when word aligned and inside [base, limit).
   function automatic logic pc_legal(input logic [31:0] pc,
                                     input logic [31:0] base,
                                     input logic [31:0] limit);
      return (pc >= base) && (pc < limit) && (pc[1:0] == 2'b00);
   endfunction

endpackage
`default_nettype wire

// File: rtl/instr_fetch_ctrl_sync_fifo.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_ctrl_sync_fifo
// Purpose  : Synchronous FIFO with flush and combinational head read.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl_sync_fifo #(
   parameter int WIDTH = 64,
   parameter int DEPTH = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic             flush,
   input  logic [WIDTH-1:0] wdata,
   output logic             full,
   output logic             empty,
   output logic [WIDTH-1:0] head
);

   localparam int             c_aw  = $clog2(DEPTH);
   localparam logic [c_aw:0]  c_one = 1;

   logic [c_aw:0]      r_wptr;
   logic [c_aw:0]      r_rptr;
   logic [WIDTH-1:0]   r_mem [DEPTH];

   always_ff @(posedge clk) begin
      if (rst || flush) begin
         r_wptr <= '0;
         r_rptr <= '0;
      end else begin
         if (push) r_wptr <= r_wptr + c_one;
         if (pop)  r_rptr <= r_rptr + c_one;
      end
   end

   always_ff @(posedge clk) begin
      if (push) r_mem[r_wptr[c_aw-1:0]] <= wdata;
   end

   // Extra pointer MSB distinguishes full from empty when the indices match.
   assign empty = (r_wptr == r_rptr);
   assign full  = (r_wptr[c_aw] != r_rptr[c_aw]) &&
                  (r_wptr[c_aw-1:0] == r_rptr[c_aw-1:0]);
   assign head  = r_mem[r_rptr[c_aw-1:0]];

endmodule
`default_nettype wire

// File: rtl/instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : instr_fetch_ctrl
// Purpose  : PC sequencing, prefetch buffering, redirects and fetch faults.
// Revision : 1.0 - initial release
// ============================================================================
module instr_fetch_ctrl
   import instr_fetch_ctrl_pkg::*;
#(
   parameter logic [31:0] RESET_PC   = c_reset_pc,
   parameter logic [31:0] TEXT_BASE  = c_text_base,
   parameter logic [31:0] TEXT_LIMIT = c_text_limit,
   parameter int          DEPTH      = c_depth
) (
   input  logic        clock,
   input  logic        clear,
   input  logic        fetch_en,
   output logic [31:0] imem_addr,
   input  logic [31:0] imem_instr,
   input  logic        redirect_valid,
   input  logic [31:0] redirect_pc,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_pc,
   output logic [31:0] out_instr,
   output logic        fault,
   output logic [31:0] fault_pc,
   output logic [31:0] fetch_count
);

   logic [31:0] r_pc;
   logic [31:0] r_fault_pc;
   logic [31:0] r_fetch_count;
   logic [0:0]  r_state;
   logic [0:0]  w_state_nxt;
   logic        w_full;
   logic        w_empty;
   logic [63:0] w_head;
   logic        w_legal;
   logic        w_room;
   logic        w_try;
   logic        w_push;
   logic        w_pop;
   logic        w_trap;

   assign w_legal = pc_legal(r_pc, TEXT_BASE, TEXT_LIMIT);
   assign w_room  = !w_full || (!w_empty && out_ready);
   assign w_try   = (r_state == c_st_run) && fetch_en && w_room && !redirect_valid;
   assign w_push  = w_try && w_legal;
   assign w_trap  = w_try && !w_legal;
   assign w_pop   = !w_empty && out_ready && !redirect_valid;

   always_ff @(posedge clock) begin
      if (clear) r_state <= c_st_run;
      else       r_state <= w_state_nxt;
   end

   always_comb begin
      w_state_nxt = r_state;
      if (redirect_valid)  w_state_nxt = c_st_run;
      else if (w_trap)     w_state_nxt = c_st_fault;
   end

   always_comb begin
      fault = (r_state == c_st_fault);
   end

   // Redirect discards this cycle's push, so neither pc nor the count advance.
   always_ff @(posedge clock) begin
      if (clear) begin
         r_pc          <= RESET_PC;
         r_fault_pc    <= 32'h0;
         r_fetch_count <= 32'h0;
      end else if (redirect_valid) begin
         r_pc <= redirect_pc;
      end else begin
         if (w_push) begin
            r_pc          <= r_pc + 32'd4;
            r_fetch_count <= r_fetch_count + 32'd1;
         end
         if (w_trap) r_fault_pc <= r_pc;
      end
   end

   instr_fetch_ctrl_sync_fifo #(
      .WIDTH (64),
      .DEPTH (DEPTH)
   ) u_fifo (
      .clk   (clock),
      .rst   (clear),
      .push  (w_push),
      .pop   (w_pop),
      .flush (redirect_valid),
      .wdata ({r_pc, imem_instr}),
      .full  (w_full),
      .empty (w_empty),
      .head  (w_head)
   );

   assign imem_addr   = r_pc;
   assign out_valid   = !w_empty;
   assign out_pc      = w_empty ? 32'h0 : w_head[63:32];
   assign out_instr   = w_empty ? c_nop : w_head[31:0];
   assign fault_pc    = r_fault_pc;
   assign fetch_count = r_fetch_count;

endmodule
`default_nettype wire

// File: tb/tb_instr_fetch_ctrl.sv
`default_nettype none
// ============================================================================
// Module   : tb_instr_fetch_ctrl
// Purpose  : Directed stimulus with a queue-based reference model for fetch.
// Revision : 1.0 - initial release
// ============================================================================
module tb_instr_fetch_ctrl;

   localparam logic [31:0] c_base  = 32'h0040_0000;
   localparam logic [31:0] c_limit = 32'h0040_0400;
   localparam int          c_depth = 4;

   logic        clock = 1'b0;
   logic        clear = 1'b1;
   logic        fetch_en = 1'b0;
   logic [31:0] imem_addr;
   logic [31:0] imem_instr;
   logic        redirect_valid = 1'b0;
   logic [31:0] redirect_pc = 32'h0;
   logic        out_valid;
   logic        out_ready = 1'b0;
   logic [31:0] out_pc;
   logic [31:0] out_instr;
   logic        fault;
   logic [31:0] fault_pc;
   logic [31:0] fetch_count;

   int n_checks = 0;
   int n_errors = 0;

   typedef struct {
      logic [31:0] pc;
      logic [31:0] instr;
   } ent_t;

   ent_t        m_q[$];
   logic [31:0] m_pc = 32'h0;
   logic        m_fault = 1'b0;
   logic [31:0] m_fault_pc = 32'h0;
   logic [31:0] m_count = 32'h0;
   bit          m_started = 1'b0;

   always #5 clock = ~clock;

   function automatic logic [31:0] mem_word(input logic [31:0] a);
      return {a[15:0] ^ 16'h5A3C, ~a[15:0]};
   endfunction

   assign imem_instr = mem_word(imem_addr);

   instr_fetch_ctrl dut (
      .clock          (clock),
      .clear          (clear),
      .fetch_en       (fetch_en),
      .imem_addr      (imem_addr),
      .imem_instr     (imem_instr),
      .redirect_valid (redirect_valid),
      .redirect_pc    (redirect_pc),
      .out_valid      (out_valid),
      .out_ready      (out_ready),
      .out_pc         (out_pc),
      .out_instr      (out_instr),
      .fault          (fault),
      .fault_pc       (fault_pc),
      .fetch_count    (fetch_count)
   );

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
      end
   endtask

   // Reference model: one step per rising edge, from the fetch rules directly.
   initial begin
      forever begin
         @(posedge clock);
         if (clear) begin
            m_q.delete();
            m_pc       = c_base;
            m_fault    = 1'b0;
            m_fault_pc = 32'h0;
            m_count    = 32'h0;
            m_started  = 1'b1;
         end else if (redirect_valid) begin
            m_q.delete();
            m_pc    = redirect_pc;
            m_fault = 1'b0;
         end else begin
            automatic bit do_pop = (m_q.size() > 0) && out_ready;
            automatic bit room   = (m_q.size() < c_depth) || do_pop;
            if (do_pop) void'(m_q.pop_front());
            if (!m_fault && fetch_en && room) begin
               if (m_pc >= c_base && m_pc < c_limit && m_pc[1:0] == 2'b00) begin
                  m_q.push_back('{pc: m_pc, instr: mem_word(m_pc)});
                  m_pc    = m_pc + 32'd4;
                  m_count = m_count + 32'd1;
               end else begin
                  m_fault    = 1'b1;
                  m_fault_pc = m_pc;
               end
            end
         end
      end
   end

   // Compare every cycle once the model has seen a clear.
   initial begin
      forever begin
         @(negedge clock);
         if (m_started) begin
            chk("m_out_valid", {31'h0, out_valid}, {31'h0, m_q.size() != 0});
            chk("m_out_pc", out_pc, (m_q.size() != 0) ? m_q[0].pc : 32'h0);
            chk("m_out_instr", out_instr, (m_q.size() != 0) ? m_q[0].instr : 32'h0);
            chk("m_imem_addr", imem_addr, m_pc);
            chk("m_fault", {31'h0, fault}, {31'h0, m_fault});
            chk("m_fault_pc", fault_pc, m_fault_pc);
            chk("m_fetch_count", fetch_count, m_count);
         end
      end
   end

   task automatic cyc(input int n);
      repeat (n) @(negedge clock);
   endtask

   initial begin
      // Reset
      cyc(2);
      chk("rst_out_valid", {31'h0, out_valid}, 32'h0);
      chk("rst_imem_addr", imem_addr, 32'h0040_0000);
      chk("rst_fetch_count", fetch_count, 32'h0);

      // 1: streaming fetch, one instruction per cycle
      clear = 1'b0; fetch_en = 1'b1; out_ready = 1'b1;
      cyc(1);
      chk("t1_pc0", out_pc, 32'h0040_0000);
      chk("t1_instr0", out_instr, 32'h5A3C_FFFF);
      chk("t1_count1", fetch_count, 32'd1);
      cyc(1);
      chk("t1_pc1", out_pc, 32'h0040_0004);
      cyc(3);
      fetch_en = 1'b0;
      cyc(2);
      chk("t1_drained", {31'h0, out_valid}, 32'h0);

      // 2: backpressure fills the buffer, then drains without gaps
      clear = 1'b1; fetch_en = 1'b1; out_ready = 1'b0;
      cyc(1);
      clear = 1'b0;
      cyc(10);
      chk("t2_pc_held", imem_addr, 32'h0040_0010);
      chk("t2_count", fetch_count, 32'd4);
      chk("t2_head", out_pc, 32'h0040_0000);
      out_ready = 1'b1;
      cyc(4);
      chk("t2_head_after", out_pc, 32'h0040_0010);
      cyc(2);

      // 3: redirect with three entries buffered
      clear = 1'b1; out_ready = 1'b0;
      cyc(1);
      clear = 1'b0;
      cyc(3);
      redirect_valid = 1'b1; redirect_pc = 32'h0040_0020;
      cyc(1);
      redirect_valid = 1'b0; out_ready = 1'b1;
      chk("t3_flushed", {31'h0, out_valid}, 32'h0);
      chk("t3_count", fetch_count, 32'd3);
      cyc(1);
      chk("t3_head", out_pc, 32'h0040_0020);
      cyc(2);

      // 4: running off the end of the text window
      redirect_valid = 1'b1; redirect_pc = 32'h0040_03F8;
      cyc(1);
      redirect_valid = 1'b0;
      cyc(3);
      chk("t4_fault", {31'h0, fault}, 32'h1);
      chk("t4_fault_pc", fault_pc, 32'h0040_0400);
      cyc(2);
      redirect_valid = 1'b1; redirect_pc = 32'h0040_0000;
      cyc(1);
      redirect_valid = 1'b0;
      chk("t4_fault_clr", {31'h0, fault}, 32'h0);
      cyc(1);
      chk("t4_resume", out_pc, 32'h0040_0000);

      // 5: misaligned redirect target
      redirect_valid = 1'b1; redirect_pc = 32'h0040_0002;
      cyc(1);
      redirect_valid = 1'b0;
      cyc(1);
      chk("t5_fault", {31'h0, fault}, 32'h1);
      chk("t5_fault_pc", fault_pc, 32'h0040_0002);

      // 6: clear beats redirect with a full buffer
      redirect_valid = 1'b1; redirect_pc = 32'h0040_0100; out_ready = 1'b0;
      cyc(1);
      redirect_valid = 1'b0;
      cyc(6);
      clear = 1'b1; redirect_valid = 1'b1; redirect_pc = 32'h0040_0200;
      cyc(1);
      clear = 1'b0; redirect_valid = 1'b0; fetch_en = 1'b0;
      chk("t6_out_valid", {31'h0, out_valid}, 32'h0);
      chk("t6_out_pc", out_pc, 32'h0);
      chk("t6_out_instr", out_instr, 32'h0);
      chk("t6_fault", {31'h0, fault}, 32'h0);
      chk("t6_fault_pc", fault_pc, 32'h0);
      chk("t6_count", fetch_count, 32'h0);
      chk("t6_pc", imem_addr, 32'h0040_0000);
      cyc(3);
      chk("t6_pc_hold", imem_addr, 32'h0040_0000);

      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
`default_nettype wire
